// File: rtl/vid_pkg.sv
// Shared constants for the video stream selector: control bit positions,
// select-width helper and the default overlay colour.
package vid_pkg;

  localparam int VDE = 0;
  localparam int HS  = 1;
  localparam int VS  = 2;

  localparam logic [23:0] OVL_COLOR_DFLT = 24'hFF00FF;

  function automatic int sel_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vid_delay.sv
// Parametrised shift register with asynchronous active-high reset;
// DEPTH of 0 degenerates to a plain wire.
module vid_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  if (DEPTH == 0) begin : g_pass
    logic w_unused;
    assign w_unused = clk ^ rst;
    assign o_q      = i_d;
  end else begin : g_sr
    logic [WIDTH-1:0] r_sr [DEPTH];

    // Shift chain, stage 0 takes the input.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) begin
          r_sr[i] <= '0;
        end
      end else begin
        r_sr[0] <= i_d;
        for (int i = 1; i < DEPTH; i++) begin
          r_sr[i] <= r_sr[i-1];
        end
      end
    end

    assign o_q = r_sr[DEPTH-1];
  end

endmodule

// File: rtl/vid_stream_sel.sv
// Latency-aligning video source selector that switches only on frame start.
// Optional overlay highlighting is enabled by defining VID_STREAM_SEL_OVERLAY_EN.
module vid_stream_sel
  import vid_pkg::*;
#(
  parameter  int          NUM_SRC   = 4,
  parameter  int          PIX_W     = 8,
  parameter  int          MAX_LAT   = 4,
  parameter  logic [31:0] LAT_VEC   = 32'h0000_3210,
  parameter  logic [23:0] OVL_COLOR = OVL_COLOR_DFLT,
  localparam int          SEL_W     = sel_w(NUM_SRC)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_SRC*3*PIX_W-1:0]   in_pix,
  input  logic [2:0]                   in_c,
  input  logic [NUM_SRC-1:0]           in_mask,
  input  logic [SEL_W-1:0]             in_sel,
  output logic [PIX_W-1:0]             out_r,
  output logic [PIX_W-1:0]             out_g,
  output logic [PIX_W-1:0]             out_b,
  output logic [2:0]                   out_ctrl,
  output logic [SEL_W-1:0]             out_sel,
  output logic                         out_sel_err
);

  localparam int PIX3_W = 3 * PIX_W;
`ifdef VID_STREAM_SEL_OVERLAY_EN
  localparam int SRC_W = PIX3_W + 1;
`else
  localparam int SRC_W = PIX3_W;
`endif
  localparam logic [SEL_W:0] NUM_SRC_L = (SEL_W+1)'(NUM_SRC);

  // Each 8-bit overlay component is left-aligned into PIX_W bits.
  localparam logic [PIX_W+7:0]  OVL_R_X = {OVL_COLOR[23:16], {PIX_W{1'b0}}};
  localparam logic [PIX_W+7:0]  OVL_G_X = {OVL_COLOR[15:8],  {PIX_W{1'b0}}};
  localparam logic [PIX_W+7:0]  OVL_B_X = {OVL_COLOR[7:0],   {PIX_W{1'b0}}};
  localparam logic [PIX3_W-1:0] OVL_PIX = {OVL_R_X[PIX_W+7:8], OVL_G_X[PIX_W+7:8],
                                           OVL_B_X[PIX_W+7:8]};

  logic [SRC_W-1:0]  w_dsrc [NUM_SRC];
  logic [2:0]        w_dc;
  logic              w_fs;
  logic              w_sel_ok;
  logic              w_err_set;
  logic [SEL_W-1:0]  w_sel_nxt;
  logic [SRC_W-1:0]  w_src_sel;
  logic [PIX3_W-1:0] w_pix_nxt;

  logic              r_vs_prev;
  logic [SEL_W-1:0]  r_active_sel;
  logic              r_sel_err;
  logic [2:0]        r_ctrl;
  logic [PIX3_W-1:0] r_pix;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    localparam int DEPTH = MAX_LAT - int'(LAT_VEC[4*k +: 4]);
    logic [SRC_W-1:0] w_src;
`ifdef VID_STREAM_SEL_OVERLAY_EN
    assign w_src = {in_mask[k], in_pix[PIX3_W*k +: PIX3_W]};
`else
    assign w_src = in_pix[PIX3_W*k +: PIX3_W];
`endif
    vid_delay #(
      .WIDTH (SRC_W),
      .DEPTH (DEPTH)
    ) u_dly (
      .clk (clk),
      .rst (rst),
      .i_d (w_src),
      .o_q (w_dsrc[k])
    );
  end

  vid_delay #(
    .WIDTH (3),
    .DEPTH (MAX_LAT)
  ) u_ctrl_dly (
    .clk (clk),
    .rst (rst),
    .i_d (in_c),
    .o_q (w_dc)
  );

`ifndef VID_STREAM_SEL_OVERLAY_EN
  logic w_unused;
  assign w_unused = ^{in_mask, OVL_PIX};
`endif

  // Frame-start select update and output pixel selection.
  always_comb begin
    w_fs      = w_dc[VS] & ~r_vs_prev;
    w_sel_ok  = ({1'b0, in_sel} < NUM_SRC_L);
    w_sel_nxt = r_active_sel;
    w_err_set = 1'b0;
    if (w_fs) begin
      if (w_sel_ok) begin
        w_sel_nxt = in_sel;
      end else begin
        w_err_set = 1'b1;
      end
    end else begin
      w_sel_nxt = r_active_sel;
    end

    w_src_sel = w_dsrc[w_sel_nxt];
    w_pix_nxt = '0;
    if (w_dc[VDE]) begin
`ifdef VID_STREAM_SEL_OVERLAY_EN
      if (w_src_sel[PIX3_W]) begin
        w_pix_nxt = OVL_PIX;
      end else begin
        w_pix_nxt = w_src_sel[PIX3_W-1:0];
      end
`else
      w_pix_nxt = w_src_sel;
`endif
    end else begin
      w_pix_nxt = '0;
    end
  end

  // Output and selection state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vs_prev    <= 1'b0;
      r_active_sel <= '0;
      r_sel_err    <= 1'b0;
      r_ctrl       <= 3'b000;
      r_pix        <= '0;
    end else begin
      r_vs_prev    <= w_dc[VS];
      r_active_sel <= w_sel_nxt;
      r_sel_err    <= r_sel_err | w_err_set;
      r_ctrl       <= w_dc;
      r_pix        <= w_pix_nxt;
    end
  end

  assign out_r       = r_pix[PIX3_W-1 -: PIX_W];
  assign out_g       = r_pix[2*PIX_W-1 -: PIX_W];
  assign out_b       = r_pix[PIX_W-1:0];
  assign out_ctrl    = r_ctrl;
  assign out_sel     = r_active_sel;
  assign out_sel_err = r_sel_err;

endmodule

// File: tb/tb_vid_stream_sel.sv
// Scoreboard bench for vid_stream_sel: expectations are derived from the input
// history with the documented latencies and compared one cycle later.
module tb_vid_stream_sel;

  localparam int NS   = 4;
  localparam int ML   = 4;
  localparam int HMAX = 512;

  typedef struct {
    int          due;
    logic [23:0] rgb;
    logic [2:0]  ctrl;
    logic [1:0]  sel;
    logic        err;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [95:0]    in_pix;
  logic [2:0]     in_c;
  logic [3:0]     in_mask;
  logic [1:0]     in_sel;
  logic [7:0]     out_r, out_g, out_b;
  logic [2:0]     out_ctrl;
  logic [1:0]     out_sel;
  logic           out_sel_err;

  logic [119:0]   in_pix5;
  logic [4:0]     in_mask5;
  logic [2:0]     in_sel5;
  logic [7:0]     o5_r, o5_g, o5_b;
  logic [2:0]     o5_ctrl;
  logic [2:0]     o5_sel;
  logic           o5_err;

  vid_stream_sel dut (
    .clk(clk), .rst(rst), .in_pix(in_pix), .in_c(in_c), .in_mask(in_mask),
    .in_sel(in_sel), .out_r(out_r), .out_g(out_g), .out_b(out_b),
    .out_ctrl(out_ctrl), .out_sel(out_sel), .out_sel_err(out_sel_err)
  );

  vid_stream_sel #(.NUM_SRC(5), .LAT_VEC(32'h0000_3210)) dut5 (
    .clk(clk), .rst(rst), .in_pix(in_pix5), .in_c(in_c), .in_mask(in_mask5),
    .in_sel(in_sel5), .out_r(o5_r), .out_g(o5_g), .out_b(o5_b),
    .out_ctrl(o5_ctrl), .out_sel(o5_sel), .out_sel_err(o5_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;
  exp_t sb[$];

  logic [23:0] h_pix  [HMAX][NS];
  logic [3:0]  h_mask [HMAX];
  logic [2:0]  h_c    [HMAX];
  int          last_rst = -1;
  logic [1:0]  m_sel = 2'd0;
  logic        m_err = 1'b0;
  logic        m_vsp = 1'b0;

  logic [23:0] b_pix [NS];
  logic [2:0]  b_c;
  logic [3:0]  b_mask;
  logic [1:0]  b_sel;
  logic [2:0]  b_sel5;
  logic        b_rst;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    exp_t        e;
    logic [2:0]  dc;
    logic [23:0] px;
    logic        mk;
    int          s;
    if (cyc >= HMAX - 2) begin
      $display("FAIL hist_overflow: observed %0d expected below %0d", cyc, HMAX - 2);
      $fatal(1, "history exhausted");
    end
    rst = b_rst; in_c = b_c; in_mask = b_mask; in_sel = b_sel; in_sel5 = b_sel5;
    in_mask5 = {1'b0, b_mask};
    for (int k = 0; k < NS; k++) begin
      in_pix[24*k +: 24]  = b_pix[k];
      in_pix5[24*k +: 24] = b_pix[k];
      h_pix[cyc][k]       = b_pix[k];
    end
    in_pix5[119:96] = 24'h505050;
    h_c[cyc]    = b_c;
    h_mask[cyc] = b_mask;
    if (b_rst) begin
      last_rst = cyc;
      m_sel = 2'd0; m_err = 1'b0; m_vsp = 1'b0;
      e.rgb = 24'h0; e.ctrl = 3'b000; e.sel = 2'd0; e.err = 1'b0;
    end else begin
      dc = (cyc - ML > last_rst) ? h_c[cyc - ML] : 3'b000;
      if (dc[2] && !m_vsp) begin
        if (int'(b_sel) < NS) m_sel = b_sel;
        else m_err = 1'b1;
      end
      m_vsp = dc[2];
      s  = cyc - (ML - int'(m_sel));
      px = (s > last_rst) ? h_pix[s][m_sel] : 24'h0;
      mk = (s > last_rst) ? h_mask[s][m_sel] : 1'b0;
`ifdef VID_STREAM_SEL_OVERLAY_EN
      if (mk) px = 24'hFF00FF;
`else
      mk = 1'b0;
`endif
      if (!dc[0]) px = 24'h0;
      e.rgb = px; e.ctrl = dc; e.sel = m_sel; e.err = m_err;
    end
    e.due = cyc + 1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        chk($sformatf("sb_rgb_c%0d", cyc), {8'h0, out_r, out_g, out_b}, {8'h0, sb[i].rgb});
        chk($sformatf("sb_ctrl_c%0d", cyc), {29'h0, out_ctrl}, {29'h0, sb[i].ctrl});
        chk($sformatf("sb_sel_c%0d", cyc), {30'h0, out_sel}, {30'h0, sb[i].sel});
        chk($sformatf("sb_err_c%0d", cyc), {31'h0, out_sel_err}, {31'h0, sb[i].err});
        sb.delete(i);
      end
    end
  endtask

  initial begin
    int t0;
    b_rst = 1'b1; b_c = 3'b000; b_mask = 4'h0; b_sel = 2'd0; b_sel5 = 3'd0;
    b_pix = '{24'h101010, 24'h202020, 24'h303030, 24'h404040};
    rst = 1'b1; in_c = 3'b000; in_mask = 4'h0; in_sel = 2'd0; in_pix = '0;
    in_pix5 = '0; in_mask5 = 5'h0; in_sel5 = 3'd0;
    @(posedge clk); #1;

    // Reset state.
    repeat (3) step();
    chk("reset_rgb", {8'h0, out_r, out_g, out_b}, 32'h0);
    chk("reset_ctrl", {29'h0, out_ctrl}, 32'h0);
    chk("reset_err5", {31'h0, o5_err}, 32'h0);

    // Frame start latches source 2 (and 4 on the 5-source instance).
    b_rst = 1'b0; b_sel = 2'd2; b_sel5 = 3'd4;
    b_c = 3'b100; step();
    b_c = 3'b101; repeat (8) step();
    chk("fs_sel2", {30'h0, out_sel}, 32'd2);
    chk("fs_sel5_4", {29'h0, o5_sel}, 32'd4);
    b_c = 3'b000; repeat (3) step();

    // Single VDE pulse with source 2 pixel aligned to it.
    t0 = cyc;
    for (int j = 0; j < 8; j++) begin
      b_c = (j == 0) ? 3'b001 : 3'b000;
      b_pix[2] = (j == 2) ? 24'hA5A5A5 : 24'h303030;
      step();
      if (cyc == t0 + 5) chk("pulse_a5", {8'h0, out_r, out_g, out_b}, 32'h00A5A5A5);
      if (cyc == t0 + 6) chk("pulse_after", {8'h0, out_r, out_g, out_b}, 32'h0);
    end

    // Blanking with nonzero pixels: black out, control delayed by 5.
    t0 = cyc;
    for (int j = 0; j < 8; j++) begin
      b_c = (j == 0) ? 3'b010 : 3'b000;
      step();
      if (cyc == t0 + 5) begin
        chk("blank_ctrl", {29'h0, out_ctrl}, 32'h2);
        chk("blank_rgb", {8'h0, out_r, out_g, out_b}, 32'h0);
      end
    end

    // Select 0, then a mid-frame request for 1 must wait for the next frame.
    b_sel = 2'd0;
    b_c = 3'b100; step();
    b_c = 3'b101; repeat (6) step();
    b_sel = 2'd1; b_sel5 = 3'd5;
    repeat (6) step();
    chk("midframe_hold", {30'h0, out_sel}, 32'd0);
    b_c = 3'b001; repeat (5) step();
    chk("vs_low_hold", {30'h0, out_sel}, 32'd0);
    t0 = cyc;
    b_c = 3'b101;
    for (int j = 0; j < 8; j++) begin
      step();
      if (cyc == t0 + 4) chk("switch_before", {30'h0, out_sel}, 32'd0);
      if (cyc == t0 + 5) begin
        chk("switch_at", {30'h0, out_sel}, 32'd1);
        chk("oor_sel_hold", {29'h0, o5_sel}, 32'd4);
        chk("oor_err_set", {31'h0, o5_err}, 32'd1);
      end
    end

    // Select changes on the very frame-start cycle take effect there.
    b_c = 3'b001; b_sel5 = 3'd1;
    repeat (5) step();
    t0 = cyc;
    b_c = 3'b101;
    for (int j = 0; j < 8; j++) begin
      b_sel = (j == 4) ? 2'd3 : 2'd1;
      step();
      if (cyc == t0 + 5) begin
        chk("same_cycle_sel", {30'h0, out_sel}, 32'd3);
        chk("sel5_after_err", {29'h0, o5_sel}, 32'd1);
        chk("err_sticky", {31'h0, o5_err}, 32'd1);
      end
      if (cyc == t0 + 6) chk("same_cycle_hold", {30'h0, out_sel}, 32'd3);
    end

    // Mid-frame reset for two cycles.
    b_c = 3'b001;
    step();
    b_rst = 1'b1;
    for (int j = 0; j < 2; j++) begin
      step();
      chk("rst_rgb", {8'h0, out_r, out_g, out_b}, 32'h0);
      chk("rst_ctrl", {29'h0, out_ctrl}, 32'h0);
      chk("rst_sel", {30'h0, out_sel}, 32'h0);
      chk("rst_err5", {31'h0, o5_err}, 32'h0);
    end
    b_rst = 1'b0;
    for (int j = 0; j < 5; j++) begin
      step();
      if (j < 4) begin
        chk("post_rst_ctrl0", {29'h0, out_ctrl}, 32'h0);
      end else begin
        chk("post_rst_ctrl", {29'h0, out_ctrl}, 32'h1);
        chk("post_rst_src0", {8'h0, out_r, out_g, out_b}, 32'h00101010);
        chk("post_rst_sel", {30'h0, out_sel}, 32'd0);
      end
    end

    // One masked pixel on the selected source 0; source 3 mask must be ignored.
    t0 = cyc;
    for (int j = 0; j < 8; j++) begin
      b_mask = (j == 1) ? 4'b0001 : 4'b1000;
      step();
      if (cyc == t0 + 6) begin
`ifdef VID_STREAM_SEL_OVERLAY_EN
        chk("overlay_hit", {8'h0, out_r, out_g, out_b}, 32'h00FF00FF);
`else
        chk("overlay_off", {8'h0, out_r, out_g, out_b}, 32'h00101010);
`endif
      end
      if (cyc == t0 + 7) chk("overlay_next", {8'h0, out_r, out_g, out_b}, 32'h00101010);
    end

    chk("sb_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
